xrv_dbus_arb: RTL and testbench
===============================

# xrv_dbus_arb

Two-master data-bus arbiter for the xriscv core. It shares one single-ported data memory or peripheral bus between master 0, the core load/store port, and master 1, a DMA/debug port. It grants one transaction at a time with round-robin priority and holds the grant until the slave returns ready. It sits between `xrv_ex`'s `d_*` port and the data SRAM/bus decoder, and uses the same req/ready protocol on every side.

## Interface
- `TIMEOUT_CYCLES`, default 256: slave-stall cycles before forced completion (used only with the timeout feature; legal range 2..65535).
- `clk  in  1`: clock; all state updates on rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `mN_addr  in  32`, N=0,1: master byte address.
- `mN_wr_req  in  1`: write request; held until `mN_wr_ready`.
- `mN_rd_req  in  1`: read request; held until `mN_rd_ready`.
- `mN_be  in  4`: byte enables.
- `mN_wr_data  in  32`: write data, already lane-aligned.
- `mN_wr_ready  out  1`: write-done pulse to master N.
- `mN_rd_ready  out  1`: read-done pulse to master N; `mN_rd_data` is valid in this cycle.
- `mN_rd_data  out  32`: read data.
- `s_addr  out  32`, `s_be  out  4`, `s_wr_data  out  32`: forwarded from the granted master.
- `s_wr_req  out  1`, `s_rd_req  out  1`: forwarded requests.
- `s_wr_ready  in  1`, `s_rd_ready  in  1`, `s_rd_data  in  32`: slave response.
- `err_timeout  out  1`: one-cycle pulse on forced completion.
- `err_master  out  1`: master ID of the last timeout; holds until the next timeout.

## Operation
- FSM states: IDLE, GNT0, GNT1. Register `last` holds the ID of the last master granted.
- A master is pending when `mN_wr_req | mN_rd_req` is high.
- IDLE:
  - Only one master pending: go to that master's GNT state.
  - Both pending: grant the master that is not `last`.
  - Neither pending: stay in IDLE.
- On entering GNTn, set `last` to n.
- GNTn:
  - `s_*` outputs are combinational copies of master n's signals.
  - `mn_wr_ready = s_wr_ready & s_wr_req`; `mn_rd_ready = s_rd_ready & s_rd_req`.
  - `mn_rd_data = s_rd_data`.
  - When either ready is seen, return to IDLE on that edge.
- Outputs in IDLE, and toward the non-granted master:
  - All ready outputs are 0.
  - All `mN_rd_data` outputs are 0.
  - `s_addr`, `s_be`, `s_wr_data`, `s_wr_req` and `s_rd_req` are all 0.
- Masters must deassert req on the edge that samples ready, as `xrv_ex` does. A req still high in IDLE is treated as a new transaction.
- `wr_req` and `rd_req` high together from one master is illegal. Both are forwarded unchanged, and the first ready seen completes the grant.
- A master dropping req while granted, without ready, is illegal. The FSM still waits for slave ready or timeout.
- The arbiter performs no address arithmetic and no byte-lane steering; all widths pass through unchanged.

## Timing
- Reset values: FSM=IDLE, `last`=1 (master 0 wins the first tie), timeout counter=0, `err_timeout`=0, `err_master`=0. Every combinational output reads 0 while `rst` is high.
- Grant latency: a req first visible in IDLE at cycle T drives `s_*_req` at T+1.
- Response path: slave ready to master ready is zero-cycle combinational.
- Back-to-back traffic: there is one IDLE bubble between transactions. With both masters continuously requesting, grants alternate 0,1,0,1.
- Reset asserted mid-grant: the FSM goes to IDLE immediately (asynchronously), the slave request drops in the same cycle, and the in-flight transaction is abandoned.

## Configuration
- Macro `XRV_DBUS_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to GNTn and increments each GNTn cycle that has no slave ready.
  - In the cycle where the counter equals `TIMEOUT_CYCLES-1` with still no ready:
    - The arbiter forces the master's ready for the pending direction (read data = 0).
    - `s_*_req` is forced to 0 in that cycle.
    - `err_timeout` pulses; `err_master` is set to n.
    - The FSM returns to IDLE.
- Macro `XRV_DBUS_ARB_TIMEOUT_EN` undefined:
  - No counter is built and a grant waits indefinitely.
  - `err_timeout` and `err_master` are tied to 0.

## Test plan
- Single read: m0 read of 0x100 at T; slave returns ready with 0x12345678 at T+3. Required: `s_rd_req` high T+1..T+3, `m0_rd_ready` high at T+3 with data 0x12345678, FSM back in IDLE at T+4.
- Simultaneous requests after reset: m0 write and m1 read both at T. Required: m0 granted at T+1. After m0 completes and one IDLE cycle, m1 is granted. m1 sees no ready while m0 is granted.
- Fairness: both masters requesting continuously with zero-wait slave ready. Required: grant sequence 0,1,0,1; each master completes 4 transactions in 16 cycles.
- Reset mid-grant: `rst` pulsed while GNT1 is active. Required: `s_rd_req`/`s_wr_req` low in the same cycle, IDLE after reset, `last`=1.
- Timeout (`XRV_DBUS_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): slave never ready on an m1 write. Required: `m1_wr_ready`, `err_timeout` and `err_master`=1 on the 4th grant cycle; `s_wr_req`=0 in that cycle. Without the macro, the grant holds for more than 100 cycles with no error.

Source files
------------

// File: rtl/xrv_dbus_arb_if.sv
// Data-bus req/ready bundle shared by both arbiter masters and the slave.
// Ports: addr/be/wr_data/wr_req/rd_req toward slave; wr_ready/rd_ready/rd_data back.
interface xrv_dbus_arb_if;
  logic [31:0] addr;
  logic        wr_req;
  logic        rd_req;
  logic [3:0]  be;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_ready;
  logic [31:0] rd_data;

  // Request side: the core, a DMA engine, or the arbiter facing the slave.
  modport master (
    output addr, wr_req, rd_req, be, wr_data,
    input  wr_ready, rd_ready, rd_data
  );

  // Response side: the SRAM/decoder, or the arbiter facing a master.
  modport slave (
    input  addr, wr_req, rd_req, be, wr_data,
    output wr_ready, rd_ready, rd_data
  );
endinterface

// File: rtl/xrv_dbus_arb.sv
// Two-master round-robin data-bus arbiter: m0 (core LSU), m1 (DMA/debug) -> s.
// Ports: clk, rst (async high), m0/m1 (slave modport), s (master modport),
// err_timeout, err_master. Optional stall timeout: XRV_DBUS_ARB_TIMEOUT_EN.
module xrv_dbus_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst,
  xrv_dbus_arb_if.slave  m0,
  xrv_dbus_arb_if.slave  m1,
  xrv_dbus_arb_if.master s,
  output logic          err_timeout,
  output logic          err_master
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("xrv_dbus_arb: TIMEOUT_CYCLES out of range 2..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last;

  logic w_g0;
  logic w_g1;
  logic w_p0;
  logic w_p1;
  logic w_wr;
  logic w_rd;
  logic w_srdy;
  logic w_to;
  logic w_done_wr;
  logic w_done_rd;

  assign w_g0 = (r_state == GNT0);
  assign w_g1 = (r_state == GNT1);
  assign w_p0 = m0.wr_req | m0.rd_req;
  assign w_p1 = m1.wr_req | m1.rd_req;

  // Requests of the granted master, before any timeout masking.
  assign w_wr = (w_g0 & m0.wr_req) | (w_g1 & m1.wr_req);
  assign w_rd = (w_g0 & m0.rd_req) | (w_g1 & m1.rd_req);

  assign s.addr    = ({32{w_g0}} & m0.addr)
                   | ({32{w_g1}} & m1.addr);
  assign s.be      = ({4{w_g0}} & m0.be)
                   | ({4{w_g1}} & m1.be);
  assign s.wr_data = ({32{w_g0}} & m0.wr_data)
                   | ({32{w_g1}} & m1.wr_data);
  assign s.wr_req  = w_wr & ~w_to;
  assign s.rd_req  = w_rd & ~w_to;

  // Any slave ready ends the grant, even if the master dropped req.
  assign w_srdy = s.wr_ready | s.rd_ready;

  assign w_done_wr = (s.wr_ready & s.wr_req) | (w_to & w_wr);
  assign w_done_rd = (s.rd_ready & s.rd_req) | (w_to & w_rd);

  assign m0.wr_ready = w_g0 & w_done_wr;
  assign m0.rd_ready = w_g0 & w_done_rd;
  assign m1.wr_ready = w_g1 & w_done_wr;
  assign m1.rd_ready = w_g1 & w_done_rd;

  // A forced completion returns zero read data.
  assign m0.rd_data = {32{w_g0 & ~w_to}} & s.rd_data;
  assign m1.rd_data = {32{w_g1 & ~w_to}} & s.rd_data;

`ifdef XRV_DBUS_ARB_TIMEOUT_EN
  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;
  logic        r_err_master;

  assign w_to = (w_g0 | w_g1) & ~w_srdy & (r_cnt == LP_LAST);

  assign err_timeout = w_to;
  // Show the new culprit in the timeout cycle itself.
  assign err_master  = w_to ? w_g1 : r_err_master;

  // Held at 0 in IDLE, so every grant starts counting from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_err_master <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_cnt <= '0;
      end else if (!w_srdy) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_to) begin
        r_err_master <= w_g1;
      end
    end
  end
`else
  assign w_to        = 1'b0;
  assign err_timeout = 1'b0;
  assign err_master  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          // On a tie, the master not granted last time wins.
          if (w_p0 && (!w_p1 || r_last)) begin
            r_state <= GNT0;
            r_last  <= 1'b0;
          end else if (w_p1) begin
            r_state <= GNT1;
            r_last  <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (w_srdy || w_to) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xrv_dbus_arb.sv
// Directed bench for xrv_dbus_arb: reset, single read, tie-break,
// fairness, reset mid-grant, and stall timeout / indefinite hold.
module tb_xrv_dbus_arb;
  logic clk = 1'b0;
  logic rst;
  logic err_timeout;
  logic err_master;

  int checks = 0;
  int failures = 0;

  xrv_dbus_arb_if m0_if ();
  xrv_dbus_arb_if m1_if ();
  xrv_dbus_arb_if s_if ();

  xrv_dbus_arb #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .err_timeout (err_timeout),
    .err_master  (err_master)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear();
    m0_if.addr = '0; m0_if.wr_req = 0; m0_if.rd_req = 0;
    m0_if.be = '0;   m0_if.wr_data = '0;
    m1_if.addr = '0; m1_if.wr_req = 0; m1_if.rd_req = 0;
    m1_if.be = '0;   m1_if.wr_data = '0;
    s_if.wr_ready = 0; s_if.rd_ready = 0; s_if.rd_data = '0;
  endtask

  initial begin
    int n0;
    int n1;
    logic e0;
    logic e1;

    // Reset: outputs all zero even with live inputs.
    rst = 1'b1;
    clear();
    m0_if.rd_req = 1; m0_if.addr = 32'h100;
    s_if.rd_ready = 1; s_if.wr_ready = 1;
    s_if.rd_data = 32'h0BAD0BAD;
    mid();
    chk1("rst_s_rd_req", s_if.rd_req, 1'b0);
    chk32("rst_s_addr", s_if.addr, 32'h0);
    chk1("rst_m0_rd_ready", m0_if.rd_ready, 1'b0);
    chk32("rst_m0_rd_data", m0_if.rd_data, 32'h0);
    chk1("rst_err_timeout", err_timeout, 1'b0);
    chk1("rst_err_master", err_master, 1'b0);
    tick();
    clear();
    tick();
    rst = 1'b0;

    // Single read by m0, ready after three grant cycles.
    m0_if.rd_req = 1; m0_if.addr = 32'h100; m0_if.be = 4'hF;
    mid();
    chk1("rd_T_idle", s_if.rd_req, 1'b0);
    tick();
    mid();
    chk1("rd_T1_req", s_if.rd_req, 1'b1);
    chk32("rd_T1_addr", s_if.addr, 32'h100);
    chk32("rd_T1_be", {28'h0, s_if.be}, 32'hF);
    tick();
    mid();
    chk1("rd_T2_req", s_if.rd_req, 1'b1);
    chk1("rd_T2_nordy", m0_if.rd_ready, 1'b0);
    tick();
    s_if.rd_ready = 1; s_if.rd_data = 32'h12345678;
    mid();
    chk1("rd_T3_req", s_if.rd_req, 1'b1);
    chk1("rd_T3_rdy", m0_if.rd_ready, 1'b1);
    chk32("rd_T3_data", m0_if.rd_data, 32'h12345678);
    chk1("rd_T3_m1rdy", m1_if.rd_ready, 1'b0);
    chk32("rd_T3_m1data", m1_if.rd_data, 32'h0);
    tick();
    // Req left high: IDLE bubble, then a fresh grant.
    s_if.rd_ready = 0;
    mid();
    chk1("rd_T4_bubble", s_if.rd_req, 1'b0);
    chk1("rd_T4_rdy", m0_if.rd_ready, 1'b0);
    tick();
    s_if.rd_ready = 1;
    mid();
    chk1("rd_T5_regrant", s_if.rd_req, 1'b1);
    tick();
    clear();

    // Reset so the tie-break starts from last=1.
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Simultaneous m0 write and m1 read.
    m0_if.wr_req = 1; m0_if.addr = 32'h200;
    m0_if.wr_data = 32'hAABBCCDD; m0_if.be = 4'h3;
    m1_if.rd_req = 1; m1_if.addr = 32'h300; m1_if.be = 4'hF;
    mid();
    chk1("tie_T_wr", s_if.wr_req, 1'b0);
    chk1("tie_T_rd", s_if.rd_req, 1'b0);
    tick();
    mid();
    chk1("tie_T1_wr", s_if.wr_req, 1'b1);
    chk1("tie_T1_rd", s_if.rd_req, 1'b0);
    chk32("tie_T1_addr", s_if.addr, 32'h200);
    chk32("tie_T1_wdata", s_if.wr_data, 32'hAABBCCDD);
    chk32("tie_T1_be", {28'h0, s_if.be}, 32'h3);
    tick();
    s_if.wr_ready = 1; s_if.rd_ready = 1;
    s_if.rd_data = 32'hDEADBEEF;
    mid();
    chk1("tie_T2_m0wr", m0_if.wr_ready, 1'b1);
    chk1("tie_T2_m0rd", m0_if.rd_ready, 1'b0);
    chk1("tie_T2_m1rd", m1_if.rd_ready, 1'b0);
    chk32("tie_T2_m1data", m1_if.rd_data, 32'h0);
    tick();
    m0_if.wr_req = 0;
    s_if.wr_ready = 0; s_if.rd_ready = 0;
    mid();
    chk1("tie_T3_bubble", s_if.rd_req, 1'b0);
    tick();
    s_if.rd_ready = 1; s_if.rd_data = 32'hCAFEF00D;
    mid();
    chk1("tie_T4_rd", s_if.rd_req, 1'b1);
    chk32("tie_T4_addr", s_if.addr, 32'h300);
    chk1("tie_T4_m1rdy", m1_if.rd_ready, 1'b1);
    chk32("tie_T4_m1data", m1_if.rd_data, 32'hCAFEF00D);
    chk1("tie_T4_m0rdy", m0_if.rd_ready, 1'b0);
    tick();
    clear();

    // Fairness: both always requesting, zero-wait slave.
    m0_if.rd_req = 1; m0_if.addr = 32'h10;
    m1_if.wr_req = 1; m1_if.addr = 32'h20;
    s_if.rd_ready = 1; s_if.wr_ready = 1;
    s_if.rd_data = 32'h55AA55AA;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 16; i++) begin
      mid();
      e0 = (i % 2 == 1) && (((i - 1) / 2) % 2 == 0);
      e1 = (i % 2 == 1) && !e0;
      if (m0_if.rd_ready === 1'b1) n0++;
      if (m1_if.wr_ready === 1'b1) n1++;
      chk1($sformatf("fair_m0_%0d", i), m0_if.rd_ready, e0);
      chk1($sformatf("fair_m1_%0d", i), m1_if.wr_ready, e1);
      tick();
    end
    clear();
    chk32("fair_n0", 32'(n0), 32'd4);
    chk32("fair_n1", 32'(n1), 32'd4);

    // Reset asserted while GNT1 is active.
    m1_if.wr_req = 1; m1_if.addr = 32'h400;
    m1_if.wr_data = 32'h11;
    mid();
    tick();
    mid();
    chk1("rmg_T1_wr", s_if.wr_req, 1'b1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk1("rmg_async_wr", s_if.wr_req, 1'b0);
    chk32("rmg_async_addr", s_if.addr, 32'h0);
    tick();
    rst = 1'b0;
    mid();
    chk1("rmg_idle", s_if.wr_req, 1'b0);
    tick();
    s_if.wr_ready = 1;
    mid();
    chk1("rmg_regrant", s_if.wr_req, 1'b1);
    chk1("rmg_m1rdy", m1_if.wr_ready, 1'b1);
    tick();
    clear();

    // Slave never ready on an m1 write.
    m1_if.wr_req = 1; m1_if.addr = 32'h500;
    mid();
    tick();
`ifdef XRV_DBUS_ARB_TIMEOUT_EN
    for (int i = 1; i < 4; i++) begin
      mid();
      chk1($sformatf("to_wr_%0d", i), s_if.wr_req, 1'b1);
      chk1($sformatf("to_err_%0d", i), err_timeout, 1'b0);
      tick();
    end
    mid();
    chk1("to_s_wr_req", s_if.wr_req, 1'b0);
    chk1("to_m1_wr_rdy", m1_if.wr_ready, 1'b1);
    chk1("to_m1_rd_rdy", m1_if.rd_ready, 1'b0);
    chk1("to_err_timeout", err_timeout, 1'b1);
    chk1("to_err_master", err_master, 1'b1);
    tick();
    clear();
    mid();
    chk1("to_err_pulse", err_timeout, 1'b0);
    chk1("to_err_hold", err_master, 1'b1);
`else
    begin
      int bad;
      bad = 0;
      repeat (110) begin
        mid();
        if (s_if.wr_req !== 1'b1 || err_timeout !== 1'b0 ||
            m1_if.wr_ready !== 1'b0 || err_master !== 1'b0)
          bad++;
        tick();
      end
      chk32("hold_bad_cycles", 32'(bad), 32'd0);
    end
    s_if.wr_ready = 1;
    mid();
    chk1("hold_done", m1_if.wr_ready, 1'b1);
    tick();
    clear();
    mid();
    chk1("hold_idle", s_if.wr_req, 1'b0);
    chk1("hold_err", err_timeout, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
